mmcm_drp_ctrl: RTL and testbench

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

---
 rtl/mmcm_pkg.sv | 64 ++++++
 rtl/mmcm_lock_sync.sv | 34 +++
 rtl/mmcm_drp_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_pkg.sv
// mmcm_pkg: shared definitions for the MMCM DRP reconfiguration controller.
//   - state_e        : controller FSM states
//   - Err*           : err_code values
//   - DivMax         : largest legal integer divide
//   - reg1_addr()    : first DRP register of each output; the second is reg1 + 1
//   - reg1_value()   : high/low time word written to reg1
//   - reg2_value()   : edge/no_count merge into the reg2 read-back word
package mmcm_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAssertRst,
    StRead,
    StWaitRd,
    StWrite,
    StWaitWr,
    StNextReg,
    StRelease,
    StWaitLock,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ErrNone        = 2'd0;
  localparam logic [1:0] ErrIllegal     = 2'd1;
  localparam logic [1:0] ErrDrpTimeout  = 2'd2;
  localparam logic [1:0] ErrLockTimeout = 2'd3;

  localparam int unsigned DivMax = 126;

  function automatic logic [6:0] reg1_addr(input logic [2:0] sel);
    logic [6:0] addr;
    case (sel)
      3'd0:    addr = 7'h08;
      3'd1:    addr = 7'h0A;
      3'd2:    addr = 7'h0C;
      3'd3:    addr = 7'h0E;
      3'd4:    addr = 7'h10;
      3'd5:    addr = 7'h06;
      3'd6:    addr = 7'h12;
      default: addr = 7'h00;
    endcase
    return addr;
  endfunction

  // Only called for legal divides (1..126), so bit 7 is always zero and the
  // 6-bit difference equals div - floor(div/2) exactly.
  function automatic logic [15:0] reg1_value(input logic [15:0] rd, input logic [6:0] div);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = div[6:1];
    lo = div[5:0] - hi;
    return {3'b000, rd[12], hi, lo};
  endfunction

  function automatic logic [15:0] reg2_value(input logic [15:0] rd, input logic [6:0] div);
    logic [15:0] val;
    val    = rd;
    val[7] = div[0];
    val[6] = (div == 7'd1);
    return val;
  endfunction

endpackage

// File: rtl/mmcm_lock_sync.sv
// mmcm_lock_sync: synchroniser for the asynchronous MMCM LOCKED signal plus
// falling-edge detect of the synchronised value.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset (all flops clear to 0)
//   async_i  : raw LOCKED from the MMCM
//   sync_o   : LOCKED after SYNC_STAGES flops
//   fall_o   : high for one cycle after sync_o drops from 1 to 0
module mmcm_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: reprograms the integer divide of one MMCM output over DRP.
// A request holds the MMCM in reset, read-modify-writes the two divider
// registers of the selected output, releases reset and waits for lock.
//   clk_in, rst_n_in        : clock (also MMCM DCLK), async active-low reset
//   cfg_valid/ready/sel/div : request handshake, output index, divide value
//   mmcm_daddr/di/do/den/dwe/drdy : DRP master port
//   mmcm_rst, mmcm_locked   : MMCM reset (active high), raw LOCKED
//   locked_sync, busy, done, err, err_code, lock_loss_cnt : status
module mmcm_drp_ctrl
  import mmcm_pkg::*;
#(
  parameter int unsigned NUM_CLKOUT   = 7,
  parameter int unsigned DRP_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_sel,
  input  logic [7:0]  cfg_div,
  output logic [6:0]  mmcm_daddr,
  output logic [15:0] mmcm_di,
  input  logic [15:0] mmcm_do,
  output logic        mmcm_den,
  output logic        mmcm_dwe,
  input  logic        mmcm_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        locked_sync,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] lock_loss_cnt
);

  localparam int unsigned TimerMax = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] DrpLast  = TimerW'(DRP_TIMEOUT - 1);
  localparam logic [TimerW-1:0] LockLast = TimerW'(LOCK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [6:0]        div_q, div_d;
  logic              idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        init_q;
  logic              rst_q, rst_d;
  logic              den_q, den_d, dwe_q, dwe_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              done_q, done_d, err_q, err_d, busy_q, busy_d, ready_q, ready_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       loss_q;
  logic              lock_fall;
  logic              illegal;

  mmcm_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .async_i(mmcm_locked),
    .sync_o (locked_sync),
    .fall_o (lock_fall)
  );

  assign illegal = (32'(cfg_sel) >= NUM_CLKOUT) || (cfg_div == 8'd0) ||
                   (32'(cfg_div) > DivMax);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    div_d      = div_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    rst_d      = rst_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        // ready_q is only ever high in idle, so it doubles as the accept gate
        if (cfg_valid && ready_q) begin
          sel_d = cfg_sel;
          div_d = cfg_div[6:0];
          if (illegal) begin
            err_code_d = ErrIllegal;
            state_d    = StErr;
          end else begin
            err_code_d = ErrNone;
            rst_d      = 1'b1;
            state_d    = StAssertRst;
          end
        end
      end
      StAssertRst: begin
        idx_d   = 1'b0;
        state_d = StRead;
      end
      StRead: begin
        timer_d = '0;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (mmcm_drdy) begin
          di_d    = idx_q ? reg2_value(mmcm_do, div_q) : reg1_value(mmcm_do, div_q);
          state_d = StWrite;
        end else if (timer_q == DrpLast) begin
          err_code_d = ErrDrpTimeout;
          state_d    = StErr;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWrite: begin
        timer_d = '0;
        state_d = StWaitWr;
      end
      StWaitWr: begin
        if (mmcm_drdy) begin
          state_d = StNextReg;
        end else if (timer_q == DrpLast) begin
          err_code_d = ErrDrpTimeout;
          state_d    = StErr;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StNextReg: begin
        if (!idx_q) begin
          idx_d   = 1'b1;
          state_d = StRead;
        end else begin
          rst_d   = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        timer_d = '0;
        state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_sync) begin
          state_d = StDone;
        end else if (timer_q == LockLast) begin
          err_code_d = ErrLockTimeout;
          state_d    = StErr;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Address is presented together with the strobe it belongs to
    if (state_d == StRead || state_d == StWrite) begin
      daddr_d = reg1_addr(sel_q) | {6'b0, idx_d};
    end

    // Second edge after reset release lets the MMCM run and opens the port
    if (init_q == 2'b01) begin
      rst_d = 1'b0;
    end

    den_d   = (state_d == StRead) || (state_d == StWrite);
    dwe_d   = (state_d == StWrite);
    done_d  = (state_d == StDone);
    err_d   = (state_d == StErr);
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && init_q[0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      div_q      <= '0;
      idx_q      <= 1'b0;
      timer_q    <= '0;
      init_q     <= 2'b00;
      rst_q      <= 1'b1;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      di_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_code_q <= ErrNone;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      init_q     <= {init_q[0], 1'b1};
      rst_q      <= rst_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_code_q <= err_code_d;
      // Lock drops caused by our own reprogramming reset are not losses
      if (lock_fall && !rst_q && (loss_q != 16'hFFFF)) begin
        loss_q <= loss_q + 16'd1;
      end
    end
  end

  assign cfg_ready     = ready_q;
  assign mmcm_daddr    = daddr_q;
  assign mmcm_di       = di_q;
  assign mmcm_den      = den_q;
  assign mmcm_dwe      = dwe_q;
  assign mmcm_rst      = rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Bench for mmcm_drp_ctrl: DRP register-file responder, MMCM lock model and a
// reference model computing the expected register writes from divide rules.
module tb_mmcm_drp_ctrl;

  localparam int unsigned NumClkout = 7;
  localparam int unsigned DrpTo     = 20;
  localparam int unsigned LockTo    = 100;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sel;
  logic [7:0]  cfg_div;
  logic [6:0]  mmcm_daddr;
  logic [15:0] mmcm_di;
  logic [15:0] mmcm_do;
  logic        mmcm_den;
  logic        mmcm_dwe;
  logic        mmcm_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        locked_sync;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] lock_loss_cnt;

  mmcm_drp_ctrl #(
    .NUM_CLKOUT  (NumClkout),
    .DRP_TIMEOUT (DrpTo),
    .LOCK_TIMEOUT(LockTo),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sel      (cfg_sel),
    .cfg_div      (cfg_div),
    .mmcm_daddr   (mmcm_daddr),
    .mmcm_di      (mmcm_di),
    .mmcm_do      (mmcm_do),
    .mmcm_den     (mmcm_den),
    .mmcm_dwe     (mmcm_dwe),
    .mmcm_drdy    (mmcm_drdy),
    .mmcm_rst     (mmcm_rst),
    .mmcm_locked  (mmcm_locked),
    .locked_sync  (locked_sync),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- DRP register file responder ----------------
  logic [15:0] mem [0:127];
  logic [6:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  logic [6:0]  pend_addr = '0;
  int          drp_cnt   = -1;
  int          den_cnt   = 0;
  bit          drp_dead  = 0;
  bit          spur_drdy = 0;

  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      drp_cnt = -1;
    end else if (mmcm_den) begin
      den_cnt++;
      pend_addr = mmcm_daddr;
      if (mmcm_dwe) begin
        mem[mmcm_daddr] = mmcm_di;
        wr_addr.push_back(mmcm_daddr);
        wr_data.push_back(mmcm_di);
      end
      drp_cnt = drp_dead ? -1 : int'($urandom_range(1, 3));
    end
    #1;
    if (drp_cnt == 0) begin
      mmcm_drdy = 1'b1;
      mmcm_do   = mem[pend_addr];
      drp_cnt   = -1;
    end else begin
      mmcm_drdy = spur_drdy;
      if (drp_cnt > 0) drp_cnt--;
    end
  end

  // ---------------- MMCM lock model ----------------
  int lock_ctr       = 0;
  bit lock_force_low = 0;

  always @(posedge clk_in) begin
    logic r;
    r = mmcm_rst;
    #1;
    if (r) lock_ctr = 0;
    else if (lock_ctr < 10) lock_ctr++;
    mmcm_locked = (lock_ctr >= 5) && !lock_force_low;
  end

  // ---------------- reference model ----------------
  int addr_tab [0:6] = '{8, 10, 12, 14, 16, 6, 18};

  function automatic bit is_legal(input int sel, input int div);
    return (sel < int'(NumClkout)) && (div >= 1) && (div <= 126);
  endfunction

  function automatic logic [15:0] exp_reg1(input logic [15:0] rd, input int div);
    int hi, lo;
    hi = div / 2;
    lo = div - hi;
    return (rd & 16'h1000) | 16'(hi * 64) | 16'(lo);
  endfunction

  function automatic logic [15:0] exp_reg2(input logic [15:0] rd, input int div);
    logic [15:0] v;
    v = rd & 16'hFF3F;
    if (div % 2 == 1) v = v | 16'h0080;
    if (div == 1)     v = v | 16'h0040;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Results of the last request
  bit r_done, r_err, r_rst_hi, r_busy1, r_ready1, r_pulse_after;
  int r_n, r_rel_n, r_den_n, r_den_delta;

  task automatic run_req(input logic [2:0] sel, input logic [7:0] div);
    int k;
    int den_base;
    k = 0;
    @(negedge clk_in);
    while (!cfg_ready && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    chk("ready_before_req", 32'(cfg_ready), 32'd1);
    wr_addr.delete();
    wr_data.delete();
    den_base  = den_cnt;
    cfg_sel   = sel;
    cfg_div   = div;
    cfg_valid = 1'b1;
    @(posedge clk_in);
    #1;
    cfg_valid = 1'b0;
    r_busy1   = busy;
    r_ready1  = cfg_ready;
    r_n = 0; r_rel_n = -1; r_den_n = -1;
    r_done = 0; r_err = 0; r_rst_hi = 0;
    while (!r_done && !r_err && r_n < 3000) begin
      @(negedge clk_in);
      r_n++;
      if (mmcm_rst) r_rst_hi = 1;
      else if (r_rst_hi && r_rel_n < 0) r_rel_n = r_n;
      if (mmcm_den) r_den_n = r_n;
      r_done = done;
      r_err  = err;
    end
    chk("req_terminates", 32'(r_done | r_err), 32'd1);
    @(negedge clk_in);
    r_pulse_after = done | err;
    r_den_delta   = den_cnt - den_base;
  endtask

  // Issue a request and compare everything against the model
  task automatic do_req(input int sel, input int div);
    logic [15:0] rd1, rd2;
    int a1;
    a1  = (sel < 7) ? addr_tab[sel] : 0;
    rd1 = mem[a1];
    rd2 = mem[a1 + 1];
    run_req(3'(sel), 8'(div));
    if (is_legal(sel, div)) begin
      chk("legal_done", 32'(r_done), 32'd1);
      chk("legal_err", 32'(r_err), 32'd0);
      chk("legal_err_code", 32'(err_code), 32'd0);
      chk("legal_den_strobes", 32'(r_den_delta), 32'd4);
      chk("busy_after_accept", 32'(r_busy1), 32'd1);
      chk("ready_low_while_busy", 32'(r_ready1), 32'd0);
      chk("done_one_cycle", 32'(r_pulse_after), 32'd0);
      chk("rst_released", 32'(mmcm_rst), 32'd0);
      chk("write_count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
        chk("reg1_addr", 32'(wr_addr[0]), 32'(a1));
        chk("reg1_data", 32'(wr_data[0]), 32'(exp_reg1(rd1, div)));
        chk("reg2_addr", 32'(wr_addr[1]), 32'(a1 + 1));
        chk("reg2_data", 32'(wr_data[1]), 32'(exp_reg2(rd2, div)));
      end
    end else begin
      chk("illegal_err", 32'(r_err), 32'd1);
      chk("illegal_done", 32'(r_done), 32'd0);
      chk("illegal_err_code", 32'(err_code), 32'd1);
      chk("illegal_den_strobes", 32'(r_den_delta), 32'd0);
      chk("illegal_rst_untouched", 32'(r_rst_hi), 32'd0);
      chk("illegal_err_latency", 32'(r_n), 32'd1);
      chk("err_one_cycle", 32'(r_pulse_after), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sel, div, sw;
    int den_base;
    rst_n_in    = 1'b0;
    cfg_valid   = 1'b0;
    cfg_sel     = '0;
    cfg_div     = '0;
    mmcm_do     = '0;
    mmcm_drdy   = 1'b0;
    mmcm_locked = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    // Reset values
    repeat (3) @(negedge clk_in);
    chk("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_outputs", {busy, done, err, err_code, mmcm_den, mmcm_dwe, locked_sync},
        32'd0);
    chk("rst_daddr_di", {9'd0, mmcm_daddr, mmcm_di}, 32'd0);
    chk("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    // Release: first edge still held, second edge opens
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("edge1_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("edge1_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk_in);
    #1;
    chk("edge2_mmcm_rst", 32'(mmcm_rst), 32'd0);
    chk("edge2_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (12) @(negedge clk_in);
    chk("initial_lock", 32'(locked_sync), 32'd1);

    // Spurious drdy in idle is ignored
    den_base  = den_cnt;
    spur_drdy = 1;
    repeat (3) @(negedge clk_in);
    chk("spur_drdy_busy", 32'(busy), 32'd0);
    spur_drdy = 0;
    @(negedge clk_in);
    chk("spur_drdy_den", 32'(den_cnt - den_base), 32'd0);

    // Output 2, divide 5, all reads 0x1000
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000;
    do_req(2, 5);
    chk("d5_err_stays_low", 32'(r_err), 32'd0);

    // Divide 1 on output 0
    mem[8] = 16'h1ABC;
    mem[9] = 16'h0000;
    do_req(0, 1);

    // Illegal requests
    do_req(7, 5);
    do_req(0, 127);
    do_req(3, 0);

    // Randomised requests
    for (int i = 0; i < 10; i++) begin
      for (int a = 6; a < 20; a++) mem[a] = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      sw  = int'($urandom_range(0, 5));
      case (sw)
        0:       div = 0;
        1:       div = 1;
        2:       div = 126;
        3:       div = 127 + int'($urandom_range(0, 128));
        default: div = int'($urandom_range(2, 125));
      endcase
      do_req(sel, div);
    end

    // Three lock drops while running
    repeat (15) @(negedge clk_in);
    chk("loss_before_drops", 32'(lock_loss_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      lock_force_low = 1;
      repeat (6) @(negedge clk_in);
      lock_force_low = 0;
      repeat (10) @(negedge clk_in);
    end
    chk("loss_after_3_drops", 32'(lock_loss_cnt), 32'd3);

    // Lock never returns
    lock_force_low = 1;
    run_req(3'd1, 8'd10);
    chk("lock_to_err", 32'(r_err), 32'd1);
    chk("lock_to_code", 32'(err_code), 32'd3);
    chk_rng("lock_to_cycles", r_n - r_rel_n, int'(LockTo), int'(LockTo) + 4);
    lock_force_low = 0;
    repeat (20) @(negedge clk_in);
    chk("loss_unchanged_by_reconfig", 32'(lock_loss_cnt), 32'd3);

    // DRP never answers
    drp_dead = 1;
    run_req(3'd4, 8'd7);
    chk("drp_to_err", 32'(r_err), 32'd1);
    chk("drp_to_code", 32'(err_code), 32'd2);
    chk("drp_to_rst_held", 32'(mmcm_rst), 32'd1);
    chk_rng("drp_to_cycles", r_n - r_den_n, int'(DrpTo), int'(DrpTo) + 3);
    chk("drp_to_single_strobe", 32'(r_den_delta), 32'd1);
    repeat (4) @(negedge clk_in);
    chk("err_code_held", 32'(err_code), 32'd2);
    drp_dead = 0;
    do_req(5, 33);

    // Reset pulse during WAIT_WR
    k = 0;
    while (!cfg_ready && k < 50) begin
      @(negedge clk_in);
      k++;
    end
    cfg_sel   = 3'd6;
    cfg_div   = 8'd12;
    cfg_valid = 1'b1;
    @(posedge clk_in);
    #1;
    cfg_valid = 1'b0;
    k = 0;
    while (!(mmcm_den && mmcm_dwe) && k < 200) begin
      @(negedge clk_in);
      k++;
    end
    chk("reached_write", 32'(mmcm_den & mmcm_dwe), 32'd1);
    @(negedge clk_in);
    den_base = den_cnt;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("midrst_outputs", {busy, done, err, err_code, mmcm_den, mmcm_dwe, cfg_ready,
        locked_sync}, 32'd0);
    chk("midrst_daddr_di", {9'd0, mmcm_daddr, mmcm_di}, 32'd0);
    chk("midrst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("midrst_no_strobe", 32'(den_cnt - den_base), 32'd0);
    do_req(6, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
